// File: rtl/clz_normalizer_pkg.sv
// Shared types and constants for the leading-zero normaliser pipeline.
// Each pipeline entry carries its data, one-hot mask, count and flags together.
package clz_normalizer_pkg;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 6;
    localparam int NSTAGES = 5;
    localparam logic [CNT_W-1:0] CNT_ZERO = 6'd32;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic [CNT_W-1:0]  cnt;
        logic              zero;
        logic              src_zero;
    } norm_entry_t;

    // Build the S1-bound entry: clamp the count, pre-zero the data for a full
    // 32-bit shift and derive the one-hot mask of the original leading one.
    function automatic norm_entry_t make_entry(logic valid, logic [DATA_W-1:0] data,
                                               logic [CNT_W-1:0] cnt);
        norm_entry_t e;
        logic [CNT_W-1:0] c;
        c          = (cnt > CNT_ZERO) ? CNT_ZERO : cnt;
        e.valid    = valid;
        e.cnt      = c;
        e.zero     = c[5];
        e.src_zero = (data == '0);
        e.data     = c[5] ? '0 : data;
        e.mask     = c[5] ? '0 : (32'h8000_0000 >> c[4:0]);
        return e;
    endfunction

endpackage

// File: rtl/clz_normalizer_if.sv
// Handshake bus of the normaliser: input side, output side and flush.
interface clz_normalizer_if;
    import clz_normalizer_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [CNT_W-1:0]  cnt_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] mask_out;
    logic              zero_out;
    logic              norm_ok;

    modport master (
        output flush, in_valid, data_in, cnt_in, out_ready,
        input  in_ready, out_valid, data_out, mask_out, zero_out, norm_ok
    );

    modport slave (
        input  flush, in_valid, data_in, cnt_in, out_ready,
        output in_ready, out_valid, data_out, mask_out, zero_out, norm_ok
    );

endinterface

// File: rtl/norm_shift_stage.sv
// One pipeline register of the normaliser; shifts the data left by SHIFT on
// the way in when count bit BIT is set.
module norm_shift_stage
    import clz_normalizer_pkg::*;
#(
    parameter int SHIFT = 16,
    parameter int BIT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  norm_entry_t d,
    output norm_entry_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (en) begin
            q <= d;
            if (d.cnt[BIT]) q.data <= d.data << SHIFT;
        end
    end

endmodule

// File: rtl/clz_normalizer.sv
// Five-stage barrel normaliser: shifts an operand left by its leading-zero
// count, emitting the leading-one mask and a count-consistency flag.
module clz_normalizer
    import clz_normalizer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    clz_normalizer_if.slave   bus
);

    norm_entry_t [NSTAGES:0] st;
    logic                    adv;
    logic                    unused_cnt;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv          = !st[NSTAGES].valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign st[0]        = make_entry(bus.in_valid, bus.data_in, bus.cnt_in);

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        norm_shift_stage #(
            .SHIFT(1 << (NSTAGES - 1 - k)),
            .BIT  (NSTAGES - 1 - k)
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (adv),
            .flush(bus.flush),
            .d    (st[k]),
            .q    (st[k+1])
        );
    end

    assign bus.out_valid = st[NSTAGES].valid;
    assign bus.data_out  = st[NSTAGES].data;
    assign bus.mask_out  = st[NSTAGES].mask;
    assign bus.zero_out  = st[NSTAGES].zero;
    // A full-width count can only be right if the operand really was zero.
    assign bus.norm_ok   = st[NSTAGES].zero ? st[NSTAGES].src_zero : st[NSTAGES].data[DATA_W-1];
    assign unused_cnt    = ^st[NSTAGES].cnt;

endmodule
